// File: rtl/icache_resp_pkg.sv
// Shared types and default geometry for the icache responder block.
// Optional perf counters are enabled by defining ICACHE_PERF_EN.
package icache_resp_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int INST_WIDTH     = 32;
    localparam int LINE_WORDS_DEF = 4;
    localparam int SETS_DEF       = 64;

    typedef enum logic [1:0] {
        IC_IDLE,
        IC_REFILL,
        IC_DRAIN,
        IC_RESP
    } icache_state_t;

    // Tag bits left after the byte offset, word-in-line and index fields.
    function automatic int tag_width(input int addr, input int line_words, input int sets);
        return addr - 2 - $clog2(line_words) - $clog2(sets);
    endfunction

endpackage

// File: rtl/icache_resp_if.sv
// Fetch-stage <-> icache handshake; active-low strobes keep their trailing underscore.
interface icache_fetch_if #(
    parameter int ADDR = 32,
    parameter int INST = 32
) ();
    logic            fetch_e_;
    logic [ADDR-1:0] fetch_pc;
    logic            flush_;
    logic            ic_e_;
    logic [ADDR-1:0] ic_pc;
    logic [INST-1:0] ic_inst;
    logic            ic_stall_;

    modport master (output fetch_e_, fetch_pc, flush_, input ic_e_, ic_pc, ic_inst, ic_stall_);
    modport slave  (input fetch_e_, fetch_pc, flush_, output ic_e_, ic_pc, ic_inst, ic_stall_);
    modport icache (input fetch_e_, fetch_pc, flush_, output ic_e_, ic_pc, ic_inst, ic_stall_);
endinterface

// File: rtl/icache_tag_array.sv
// Tag RAM with registered read plus per-line valid flops that support a flash clear.
module icache_tag_array #(
    parameter int SETS  = 64,
    parameter int IDX_W = 6,
    parameter int TAG_W = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             clear
);
    logic [TAG_W-1:0] tag_mem [SETS];
    logic [TAG_W-1:0] rd_tag_reg;
    logic             rd_valid_reg;
    logic [SETS-1:0]  valid_reg;

    always_ff @(posedge clk) begin
        if (wr_en)
            tag_mem[wr_idx] <= wr_tag;
        if (rd_en)
            rd_tag_reg <= tag_mem[rd_idx];
    end

    // Clear wins over a write landing on the same edge.
    for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
        logic valid_bit_reg;
        always_ff @(posedge clk) begin
            if (reset || clear)
                valid_bit_reg <= 1'b0;
            else if (wr_en && wr_idx == IDX_W'(gi))
                valid_bit_reg <= 1'b1;
        end
        assign valid_reg[gi] = valid_bit_reg;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rd_valid_reg <= 1'b0;
        else if (rd_en)
            rd_valid_reg <= valid_reg[rd_idx];
    end

    assign rd_tag   = rd_tag_reg;
    assign rd_valid = rd_valid_reg;
endmodule

// File: rtl/icache_resp.sv
// Direct-mapped blocking instruction cache, one-cycle hit, word-by-word line refill.
// Define ICACHE_PERF_EN to add saturating hit/miss counters.
module icache_resp
    import icache_resp_pkg::*;
#(
    parameter int ADDR       = ADDR_WIDTH,
    parameter int INST       = INST_WIDTH,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int SETS       = SETS_DEF
) (
    input  logic            clk,
    input  logic            reset,
    icache_fetch_if.icache  ic_fetch,
    output logic            mem_rd_,
    output logic [ADDR-1:0] mem_addr,
    input  logic            mem_ack_,
    input  logic [INST-1:0] mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]     perf_hit,
    output logic [31:0]     perf_miss
`endif
);
    localparam int OFS_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = tag_width(ADDR, LINE_WORDS, SETS);
    localparam int DEPTH = SETS * LINE_WORDS;

    icache_state_t    state_reg, state_next;
    logic             lookup_reg;
    logic [ADDR-1:0]  pc_reg;
    logic [OFS_W-1:0] word_cnt_reg;
    logic [INST-1:0]  data_q_reg, resp_inst_reg, inst_hold_reg;
    logic [INST-1:0]  data_mem [DEPTH];

    logic             accept, hit_now, miss_now;
    logic             rd_n, resp_e_n, stall_n, refill_wr, tag_wr;
    logic [INST-1:0]  inst_out;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;

    logic [OFS_W-1:0] fetch_word, miss_word;
    logic [IDX_W-1:0] fetch_idx, miss_idx;
    logic [TAG_W-1:0] miss_tag;

    assign fetch_word = ic_fetch.fetch_pc[2 +: OFS_W];
    assign fetch_idx  = ic_fetch.fetch_pc[2 + OFS_W +: IDX_W];
    assign miss_word  = pc_reg[2 +: OFS_W];
    assign miss_idx   = pc_reg[2 + OFS_W +: IDX_W];
    assign miss_tag   = pc_reg[ADDR-1 -: TAG_W];

    // The cycle a miss shows, fetch is still holding its request; it must not re-enter.
    assign hit_now  = lookup_reg && rd_valid && (rd_tag == miss_tag);
    assign miss_now = lookup_reg && !hit_now;
    assign accept   = (state_reg == IC_IDLE) && !ic_fetch.fetch_e_ && ic_fetch.flush_ && !miss_now;

    icache_tag_array #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_tags (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (accept),
        .rd_idx   (fetch_idx),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .wr_en    (tag_wr),
        .wr_idx   (miss_idx),
        .wr_tag   (miss_tag),
        .clear    (!ic_fetch.flush_)
    );

    always_ff @(posedge clk) begin
        if (refill_wr)
            data_mem[{miss_idx, word_cnt_reg}] <= mem_rdata;
        if (accept)
            data_q_reg <= data_mem[{fetch_idx, fetch_word}];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IC_IDLE;
            lookup_reg    <= 1'b0;
            pc_reg        <= '0;
            word_cnt_reg  <= '0;
            resp_inst_reg <= '0;
            inst_hold_reg <= '0;
        end else begin
            state_reg     <= state_next;
            lookup_reg    <= accept;
            inst_hold_reg <= inst_out;
            if (accept)
                pc_reg <= ic_fetch.fetch_pc;
            if (state_reg == IC_IDLE)
                word_cnt_reg <= '0;
            else if (refill_wr)
                word_cnt_reg <= word_cnt_reg + 1'b1;
            if (refill_wr && word_cnt_reg == miss_word)
                resp_inst_reg <= mem_rdata;
        end
    end

    always_comb begin
        state_next = state_reg;
        rd_n       = 1'b1;
        resp_e_n   = 1'b1;
        stall_n    = 1'b1;
        refill_wr  = 1'b0;
        tag_wr     = 1'b0;
        case (state_reg)
            IC_IDLE: begin
                if (hit_now && ic_fetch.flush_)
                    resp_e_n = 1'b0;
                if (miss_now && ic_fetch.flush_) begin
                    stall_n    = 1'b0;
                    state_next = IC_REFILL;
                end
            end
            IC_REFILL: begin
                stall_n = 1'b0;
                rd_n    = 1'b0;
                if (!mem_ack_) begin
                    // An ack alongside a flush retires the only outstanding request.
                    if (!ic_fetch.flush_)
                        state_next = IC_IDLE;
                    else begin
                        refill_wr = 1'b1;
                        if (word_cnt_reg == OFS_W'(LINE_WORDS - 1)) begin
                            tag_wr     = 1'b1;
                            state_next = IC_RESP;
                        end
                    end
                end else if (!ic_fetch.flush_)
                    state_next = IC_DRAIN;
            end
            IC_DRAIN: begin
                stall_n = 1'b0;
                rd_n    = 1'b0;
                if (!mem_ack_)
                    state_next = IC_IDLE;
            end
            IC_RESP: begin
                resp_e_n   = !ic_fetch.flush_;
                state_next = IC_IDLE;
            end
            default: state_next = IC_IDLE;
        endcase
    end

    assign inst_out = resp_e_n ? inst_hold_reg
                    : ((state_reg == IC_RESP) ? resp_inst_reg : data_q_reg);

    assign ic_fetch.ic_e_     = resp_e_n;
    assign ic_fetch.ic_stall_ = stall_n;
    assign ic_fetch.ic_pc     = pc_reg;
    assign ic_fetch.ic_inst   = inst_out;
    assign mem_rd_            = rd_n;
    assign mem_addr           = {pc_reg[ADDR-1:2+OFS_W], word_cnt_reg, 2'b00};

`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit_reg, perf_miss_reg;
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_hit_reg  <= '0;
            perf_miss_reg <= '0;
        end else begin
            if (hit_now && perf_hit_reg != '1)
                perf_hit_reg <= perf_hit_reg + 1'b1;
            if (miss_now && perf_miss_reg != '1)
                perf_miss_reg <= perf_miss_reg + 1'b1;
        end
    end
    assign perf_hit  = perf_hit_reg;
    assign perf_miss = perf_miss_reg;
`endif
endmodule

// File: tb/tb_icache_resp.sv
// Directed bench for icache_resp: cold miss, hit streaming, conflict, flushes, reset mid-refill.
// Counter checks are included when ICACHE_PERF_EN is defined.
module tb_icache_resp;
    logic        clk;
    logic        reset;
    logic        mem_rd_;
    logic [31:0] mem_addr;
    logic        mem_ack_;
    logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit, perf_miss;
`endif
    int compared   = 0;
    int mismatched = 0;

    icache_fetch_if #(.ADDR(32), .INST(32)) bus ();

    icache_resp dut (
        .clk       (clk),
        .reset     (reset),
        .ic_fetch  (bus),
        .mem_rd_   (mem_rd_),
        .mem_addr  (mem_addr),
        .mem_ack_  (mem_ack_),
        .mem_rdata (mem_rdata)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hit  (perf_hit),
        .perf_miss (perf_miss)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return 32'hD000_0000 | a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Enter the next cycle; a memory ack lasts exactly one cycle.
    task automatic step();
        @(posedge clk);
        #1;
        mem_ack_ = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        bus.fetch_e_ = 1'b0;
        bus.fetch_pc = pc;
    endtask

    // Wait (bounded) for a read request, check its address, ack it this cycle.
    task automatic serve(input logic [31:0] a);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            #1;
            if (!mem_rd_) seen = 1'b1;
        end
        chk("mem_req_seen", 64'(seen), 64'd1);
        chk("mem_addr", 64'(mem_addr), 64'(a));
        mem_ack_  = 1'b0;
        mem_rdata = mdata(a);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        bus.fetch_e_ = 1'b1;
        bus.fetch_pc = '0;
        bus.flush_   = 1'b1;
        mem_ack_     = 1'b1;
        mem_rdata    = '0;
        repeat (3) step();
        #1;
        chk("rst_ic_e", 64'(bus.ic_e_), 64'd1);
        chk("rst_stall", 64'(bus.ic_stall_), 64'd1);
        chk("rst_ic_pc", 64'(bus.ic_pc), 64'd0);
        chk("rst_ic_inst", 64'(bus.ic_inst), 64'd0);
        chk("rst_mem_rd", 64'(mem_rd_), 64'd1);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);

        // 1: cold miss on 0x100
        step(); reset = 1'b0; fetch(32'h100);
        step(); #1;
        chk("t1_stall", 64'(bus.ic_stall_), 64'd0);
        chk("t1_ic_e", 64'(bus.ic_e_), 64'd1);
        serve(32'h100); serve(32'h104); serve(32'h108);
        chk("t1_stall_refill", 64'(bus.ic_stall_), 64'd0);
        serve(32'h10C);
        step(); bus.fetch_e_ = 1'b1; #1;
        chk("t1_resp_e", 64'(bus.ic_e_), 64'd0);
        chk("t1_resp_pc", 64'(bus.ic_pc), 64'h100);
        chk("t1_resp_inst", 64'(bus.ic_inst), 64'hD0000100);
        chk("t1_resp_stall", 64'(bus.ic_stall_), 64'd1);

        // 2: back-to-back hits
        step(); fetch(32'h100);
        step(); fetch(32'h104); #1;
        chk("t2_e0", 64'(bus.ic_e_), 64'd0);
        chk("t2_pc0", 64'(bus.ic_pc), 64'h100);
        chk("t2_inst0", 64'(bus.ic_inst), 64'hD0000100);
        step(); fetch(32'h108); #1;
        chk("t2_e1", 64'(bus.ic_e_), 64'd0);
        chk("t2_pc1", 64'(bus.ic_pc), 64'h104);
        chk("t2_inst1", 64'(bus.ic_inst), 64'hD0000104);
        step(); fetch(32'h10C); #1;
        chk("t2_e2", 64'(bus.ic_e_), 64'd0);
        chk("t2_inst2", 64'(bus.ic_inst), 64'hD0000108);
        step(); bus.fetch_e_ = 1'b1; #1;
        chk("t2_e3", 64'(bus.ic_e_), 64'd0);
        chk("t2_pc3", 64'(bus.ic_pc), 64'h10C);
        chk("t2_inst3", 64'(bus.ic_inst), 64'hD000010C);
        step(); #1;
        chk("t2_idle_e", 64'(bus.ic_e_), 64'd1);
        chk("t2_inst_hold", 64'(bus.ic_inst), 64'hD000010C);

        // 3: conflict 0x500 evicts 0x100
        step(); fetch(32'h500);
        step(); #1;
        chk("t3_miss500", 64'(bus.ic_stall_), 64'd0);
        serve(32'h500); serve(32'h504); serve(32'h508); serve(32'h50C);
        step(); bus.fetch_e_ = 1'b1; #1;
        chk("t3_resp_e", 64'(bus.ic_e_), 64'd0);
        chk("t3_resp_pc", 64'(bus.ic_pc), 64'h500);
        chk("t3_resp_inst", 64'(bus.ic_inst), 64'hD0000500);
        step(); fetch(32'h100);
        step(); #1;
        chk("t3_refetch_miss", 64'(bus.ic_stall_), 64'd0);
        serve(32'h100); serve(32'h104); serve(32'h108); serve(32'h10C);
        step(); bus.fetch_e_ = 1'b1; #1;
        chk("t3_refetch_e", 64'(bus.ic_e_), 64'd0);
        chk("t3_refetch_inst", 64'(bus.ic_inst), 64'hD0000100);

        // 4: flush while the third word is outstanding
        step(); fetch(32'h200);
        step(); #1;
        chk("t4_miss", 64'(bus.ic_stall_), 64'd0);
        serve(32'h200); serve(32'h204);
        step(); #1;
        chk("t4_rd_w2", 64'(mem_rd_), 64'd0);
        chk("t4_addr_w2", 64'(mem_addr), 64'h208);
        bus.fetch_e_ = 1'b1; bus.flush_ = 1'b0; #1;
        step(); bus.flush_ = 1'b1; #1;
        chk("t4_drain_rd", 64'(mem_rd_), 64'd0);
        chk("t4_drain_addr", 64'(mem_addr), 64'h208);
        chk("t4_drain_stall", 64'(bus.ic_stall_), 64'd0);
        chk("t4_drain_e", 64'(bus.ic_e_), 64'd1);
        mem_ack_ = 1'b0; mem_rdata = mdata(32'h208); #1;
        step(); #1;
        chk("t4_post_rd", 64'(mem_rd_), 64'd1);
        chk("t4_post_stall", 64'(bus.ic_stall_), 64'd1);
        chk("t4_post_e", 64'(bus.ic_e_), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("t4_quiet_rd", 64'(mem_rd_), 64'd1);
            chk("t4_quiet_e", 64'(bus.ic_e_), 64'd1);
        end
        step(); fetch(32'h200);
        step(); #1;
        chk("t4_refetch_miss", 64'(bus.ic_stall_), 64'd0);
        serve(32'h200); serve(32'h204); serve(32'h208); serve(32'h20C);
        step(); bus.fetch_e_ = 1'b1; #1;
        chk("t4_resp_e", 64'(bus.ic_e_), 64'd0);
        chk("t4_resp_pc", 64'(bus.ic_pc), 64'h200);
        chk("t4_resp_inst", 64'(bus.ic_inst), 64'hD0000200);

        // 5: flush and fetch in the same cycle on a warm line
        step(); fetch(32'h200); bus.flush_ = 1'b0;
        step(); bus.fetch_e_ = 1'b1; bus.flush_ = 1'b1; #1;
        chk("t5_flush_e", 64'(bus.ic_e_), 64'd1);
        chk("t5_flush_stall", 64'(bus.ic_stall_), 64'd1);
        step(); fetch(32'h20C);
        step(); #1;
        chk("t5_after_miss", 64'(bus.ic_stall_), 64'd0);
        chk("t5_after_e", 64'(bus.ic_e_), 64'd1);

        // 6: reset in the middle of that refill
        serve(32'h200); serve(32'h204);
        step(); #1;
        chk("t6_rd_before", 64'(mem_rd_), 64'd0);
`ifdef ICACHE_PERF_EN
        chk("t6_perf_hit", 64'(perf_hit), 64'd4);
        chk("t6_perf_miss", 64'(perf_miss), 64'd6);
`endif
        reset = 1'b1; bus.fetch_e_ = 1'b1;
        step(); #1;
        chk("t6_rd", 64'(mem_rd_), 64'd1);
        chk("t6_stall", 64'(bus.ic_stall_), 64'd1);
        chk("t6_e", 64'(bus.ic_e_), 64'd1);
`ifdef ICACHE_PERF_EN
        chk("t6_perf_hit0", 64'(perf_hit), 64'd0);
        chk("t6_perf_miss0", 64'(perf_miss), 64'd0);
`endif
        reset = 1'b0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
